// File: rtl/apf_video_pkg.sv
// Shared types and constants for the APF video receiver: FSM states,
// error-bit indices, sync spacing and command-word field positions.
package apf_video_pkg;

    typedef enum logic [0:0] {
        S_WAIT_VS = 1'b0,
        S_LOCKED  = 1'b1
    } state_t;

    localparam int unsigned RGB_W = 24;

    localparam int unsigned ERR_W      = 6;
    localparam int unsigned ERR_VS_HS  = 0;
    localparam int unsigned ERR_DEF_HS = 1;
    localparam int unsigned ERR_HS_DE  = 2;
    localparam int unsigned ERR_LONG   = 3;
    localparam int unsigned ERR_HACT   = 4;
    localparam int unsigned ERR_DE_VS  = 5;

    // Minimum clocks from a VS pulse to the next HS pulse
    localparam int unsigned VS_HS_GAP = 3;

    localparam int unsigned CMD_RESCAN     = 0;
    localparam int unsigned CMD_INTERLACED = 1;
    localparam int unsigned CMD_FIELD      = 2;
    localparam int unsigned CMD_LAST_FIELD = 3;
    localparam int unsigned CMD_SLOT_LSB   = 13;
    localparam int unsigned CMD_SLOT_W     = 3;

endpackage

// File: rtl/apf_gap_checker.sv
// Sync/DE protocol checker: edge and spacing detection, sticky error flags
// and a saturating count of clocks containing any violation.
module apf_gap_checker
    import apf_video_pkg::*;
#(
    parameter int unsigned ECW = 16
) (
    input  logic             clk_vid,
    input  logic             reset_n,
    input  logic             active,
    input  logic             hs,
    input  logic             vs,
    input  logic             de,
    input  logic             hact_err,
    input  logic             clr_err,
    output logic [ERR_W-1:0] err_flags,
    output logic [ECW-1:0]   err_count
);

    localparam int unsigned HIST_W = VS_HS_GAP - 1;

    logic [HIST_W-1:0] vs_hist;
    logic              hs_d1;
    logic              de_d1;
    logic [ERR_W-1:0]  viol_c;

    // Strobe history tracks even while unlocked so the first locked cycles see it
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            vs_hist <= '0;
            hs_d1   <= 1'b0;
            de_d1   <= 1'b0;
        end else begin
            vs_hist <= {vs_hist[HIST_W-2:0], vs};
            hs_d1   <= hs;
            de_d1   <= de;
        end
    end

    always_comb begin
        viol_c = '0;
        if (active) begin
            viol_c[ERR_VS_HS]  = hs && (vs || (|vs_hist));
            viol_c[ERR_DEF_HS] = hs && de_d1 && !de;
            viol_c[ERR_HS_DE]  = de && (hs || hs_d1);
            viol_c[ERR_LONG]   = (hs && hs_d1) || (vs && vs_hist[0]);
            viol_c[ERR_HACT]   = hact_err;
            viol_c[ERR_DE_VS]  = de && vs;
        end
    end

    // A violation in the clearing cycle survives the clear
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            err_flags <= '0;
            err_count <= '0;
        end else if (clr_err) begin
            err_flags <= viol_c;
            err_count <= (|viol_c) ? ECW'(1) : '0;
        end else begin
            err_flags <= err_flags | viol_c;
            if ((|viol_c) && !(&err_count))
                err_count <= err_count + ECW'(1);
        end
    end

endmodule

// File: rtl/apf_video_rx.sv
// APF video receiver: locks on VS, decodes the active-pixel stream and
// measures frame timing; protocol checking is delegated to apf_gap_checker.
module apf_video_rx
    import apf_video_pkg::*;
#(
    parameter int unsigned CW  = 12,
    parameter int unsigned ECW = 16
) (
    input  logic             clk_vid,
    input  logic             reset_n,
    input  logic [RGB_W-1:0] video_rgb,
    input  logic             video_hs,
    input  logic             video_vs,
    input  logic             video_de,
    input  logic             clr_err,
    output logic             pix_valid,
    output logic [RGB_W-1:0] pix_rgb,
    output logic [CW-1:0]    pix_x,
    output logic [CW-1:0]    pix_y,
    output logic [CW-1:0]    h_active,
    output logic [CW-1:0]    h_total,
    output logic [CW-1:0]    v_active,
    output logic [CW-1:0]    v_total,
    output logic             interlaced,
    output logic             field,
    output logic             last_field,
    output logic             rescan,
    output logic [2:0]       scaler_slot,
    output logic             slot_valid,
    output logic             frame_done,
    output logic             locked,
    output logic [ERR_W-1:0] err_flags,
    output logic [ECW-1:0]   err_count
);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    state_t        state;
    state_t        state_nxt;
    logic          locked_c;
    logic          de_d;
    logic          de_fall_c;
    logic          hact_err_c;
    logic          seen_hs;
    logic          have_prev;
    logic          skip_line;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] hs_lines;
    logic [CW-1:0] de_cnt;
    logic [CW-1:0] y_cnt;

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) state <= S_WAIT_VS;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == S_WAIT_VS && video_vs)
            state_nxt = S_LOCKED;
    end

    always_comb begin
        locked_c = (state == S_LOCKED);
    end

    assign locked     = locked_c;
    assign de_fall_c  = locked_c && de_d && !video_de;
    assign hact_err_c = de_fall_c && !skip_line && have_prev && (de_cnt != h_active);

    // Later assignments in this block take priority: VS resets override line updates
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            de_d        <= 1'b0;
            pix_valid   <= 1'b0;
            pix_rgb     <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            h_active    <= '0;
            h_total     <= '0;
            v_active    <= '0;
            v_total     <= '0;
            interlaced  <= 1'b0;
            field       <= 1'b0;
            last_field  <= 1'b0;
            rescan      <= 1'b0;
            scaler_slot <= '0;
            slot_valid  <= 1'b0;
            frame_done  <= 1'b0;
            seen_hs     <= 1'b0;
            have_prev   <= 1'b0;
            skip_line   <= 1'b0;
            hcnt        <= '0;
            hs_lines    <= '0;
            de_cnt      <= '0;
            y_cnt       <= '0;
        end else begin
            de_d       <= video_de;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;

            if (video_vs) begin
                interlaced <= video_rgb[CMD_INTERLACED];
                field      <= video_rgb[CMD_FIELD];
                last_field <= video_rgb[CMD_LAST_FIELD];
                rescan     <= video_rgb[CMD_RESCAN];
            end

            if (locked_c) begin
                if (video_hs) begin
                    hcnt     <= CW'(1);
                    seen_hs  <= 1'b1;
                    hs_lines <= sat_inc(hs_lines);
                    if (seen_hs) h_total <= hcnt;
                end else begin
                    hcnt <= sat_inc(hcnt);
                end

                if (video_de) begin
                    pix_valid <= 1'b1;
                    pix_rgb   <= video_rgb;
                    pix_x     <= de_cnt;
                    pix_y     <= y_cnt;
                    de_cnt    <= sat_inc(de_cnt);
                end

                if (de_fall_c) begin
                    de_cnt      <= '0;
                    y_cnt       <= sat_inc(y_cnt);
                    scaler_slot <= video_rgb[CMD_SLOT_LSB +: CMD_SLOT_W];
                    slot_valid  <= 1'b1;
                    skip_line   <= 1'b0;
                    if (!skip_line) begin
                        h_active  <= de_cnt;
                        have_prev <= 1'b1;
                    end
                end

                // A line still in DE at VS is partial and must not be measured
                if (video_vs) begin
                    v_total    <= hs_lines;
                    v_active   <= y_cnt;
                    frame_done <= 1'b1;
                    hs_lines   <= '0;
                    y_cnt      <= '0;
                    de_cnt     <= '0;
                    have_prev  <= 1'b0;
                    skip_line  <= video_de;
                end
            end
        end
    end

    apf_gap_checker #(
        .ECW (ECW)
    ) u_gap_checker (
        .clk_vid   (clk_vid),
        .reset_n   (reset_n),
        .active    (locked_c),
        .hs        (video_hs),
        .vs        (video_vs),
        .de        (video_de),
        .hact_err  (hact_err_c),
        .clr_err   (clr_err),
        .err_flags (err_flags),
        .err_count (err_count)
    );

endmodule

// File: tb/tb_apf_video_rx.sv
// Directed bench for apf_video_rx: frame timing, feature bits, protocol
// errors, scaler command and mid-frame reset behaviour.
module tb_apf_video_rx;

    logic        clk_vid = 1'b0;
    logic        reset_n;
    logic [23:0] video_rgb;
    logic        video_hs;
    logic        video_vs;
    logic        video_de;
    logic        clr_err;
    logic        pix_valid;
    logic [23:0] pix_rgb;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic [11:0] h_active;
    logic [11:0] h_total;
    logic [11:0] v_active;
    logic [11:0] v_total;
    logic        interlaced;
    logic        field;
    logic        last_field;
    logic        rescan;
    logic [2:0]  scaler_slot;
    logic        slot_valid;
    logic        frame_done;
    logic        locked;
    logic [5:0]  err_flags;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int pv_cnt = 0;
    int fd_base;
    int pv_base;

    apf_video_rx dut (
        .clk_vid     (clk_vid),
        .reset_n     (reset_n),
        .video_rgb   (video_rgb),
        .video_hs    (video_hs),
        .video_vs    (video_vs),
        .video_de    (video_de),
        .clr_err     (clr_err),
        .pix_valid   (pix_valid),
        .pix_rgb     (pix_rgb),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .h_active    (h_active),
        .h_total     (h_total),
        .v_active    (v_active),
        .v_total     (v_total),
        .interlaced  (interlaced),
        .field       (field),
        .last_field  (last_field),
        .rescan      (rescan),
        .scaler_slot (scaler_slot),
        .slot_valid  (slot_valid),
        .frame_done  (frame_done),
        .locked      (locked),
        .err_flags   (err_flags),
        .err_count   (err_count)
    );

    always #5 clk_vid = ~clk_vid;

    always @(negedge clk_vid) begin
        if (frame_done) fd_cnt += 1;
        if (pix_valid)  pv_cnt += 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks += 1;
        assert (obs === exp) else begin
            errors += 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs; return 1 time unit after the sampling edge
    task automatic cyc(input logic hs, input logic vs, input logic de, input logic [23:0] rgb);
        video_hs  = hs;
        video_vs  = vs;
        video_de  = de;
        video_rgb = rgb;
        @(posedge clk_vid);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    // 16-clock line: HS, 3 blank, n DE clocks, fall cycle carrying fall_rgb, blank
    task automatic line(input int n, input logic [23:0] fall_rgb);
        cyc(1'b1, 1'b0, 1'b0, 24'h0);
        idle(3);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 24'h111111 * (i + 1));
        cyc(1'b0, 1'b0, 1'b0, fall_rgb);
        idle(11 - n);
    endtask

    initial begin
        reset_n   = 1'b0;
        video_rgb = '0;
        video_hs  = 1'b0;
        video_vs  = 1'b0;
        video_de  = 1'b0;
        clr_err   = 1'b0;
        repeat (3) @(posedge clk_vid);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_slot_valid", slot_valid, 0);
        chk("rst_err_flags", err_flags, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_h_total", h_total, 0);
        chk("rst_pix_valid", pix_valid, 0);
        reset_n = 1'b1;

        // Basic frame: lock, 4 lines of 8 DE at HS period 16, closing VS
        fd_base = fd_cnt;
        cyc(1'b0, 1'b1, 1'b0, 24'h0);
        chk("lock", locked, 1);
        chk("lock_no_frame_done", frame_done, 0);
        idle(2);
        for (int l = 0; l < 4; l++) line(8, 24'h0);
        cyc(1'b0, 1'b1, 1'b0, 24'h0);
        chk("frame_done_pulse", frame_done, 1);
        chk("h_active", h_active, 8);
        chk("h_total", h_total, 16);
        chk("v_active", v_active, 4);
        chk("v_total", v_total, 4);
        chk("frame_err_flags", err_flags, 0);
        idle(2);
        chk("frame_done_once", fd_cnt - fd_base, 1);

        // Pixel coordinates on the first two lines of the new frame
        cyc(1'b1, 1'b0, 1'b0, 24'h0);
        idle(3);
        cyc(1'b0, 1'b0, 1'b1, 24'h123456);
        chk("pix_valid", pix_valid, 1);
        chk("pix_x_first", pix_x, 0);
        chk("pix_y_first", pix_y, 0);
        chk("pix_rgb", pix_rgb, 24'h123456);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 24'h0);
        chk("pix_x_last", pix_x, 7);
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
        chk("pix_valid_low", pix_valid, 0);
        idle(3);
        cyc(1'b1, 1'b0, 1'b0, 24'h0);
        idle(3);
        cyc(1'b0, 1'b0, 1'b1, 24'h0);
        chk("pix_y_second", pix_y, 1);
        chk("pix_x_second", pix_x, 0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 24'h0);
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
        idle(3);

        // Feature bits latched from the VS command word
        cyc(1'b0, 1'b1, 1'b0, 24'h00000E);
        chk("interlaced", interlaced, 1);
        chk("field", field, 1);
        chk("last_field", last_field, 1);
        chk("rescan", rescan, 0);
        chk("feature_err_flags", err_flags, 0);
        idle(2);

        // h_active change within a frame and scaler slot command
        line(8, 24'h0);
        line(7, 24'h00A000);
        chk("hact_err_flags", err_flags, 6'b010000);
        chk("hact_err_count", err_count, 1);
        chk("h_active_7", h_active, 7);
        chk("scaler_slot", scaler_slot, 5);
        chk("slot_valid", slot_valid, 1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("clr1_flags", err_flags, 0);
        chk("clr1_count", err_count, 0);

        // HS two clocks after VS, DE right after HS
        cyc(1'b0, 1'b1, 1'b0, 24'h0);
        idle(1);
        cyc(1'b1, 1'b0, 1'b0, 24'h0);
        cyc(1'b0, 1'b0, 1'b1, 24'h0);
        cyc(1'b0, 1'b0, 1'b0, 24'h0);
        chk("gap_err_flags", err_flags, 6'b000101);
        chk("gap_err_count", err_count, 2);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("clr2_flags", err_flags, 0);
        chk("clr2_count", err_count, 0);

        // Violation in the same cycle as clr_err is kept
        idle(3);
        clr_err = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 24'h0);
        clr_err = 1'b0;
        chk("clr_win_flags", err_flags, 6'b000100);
        chk("clr_win_count", err_count, 1);
        idle(16);

        // Two-clock HS pulse
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 24'h0);
        cyc(1'b1, 1'b0, 1'b0, 24'h0);
        idle(1);
        chk("long_hs_flags", err_flags, 6'b001000);
        chk("long_hs_count", err_count, 1);

        // Reset mid-line, then traffic with no VS
        cyc(1'b1, 1'b0, 1'b0, 24'h0);
        idle(3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 24'h0);
        reset_n = 1'b0;
        #1;
        chk("midrst_locked", locked, 0);
        chk("midrst_pix_valid", pix_valid, 0);
        chk("midrst_h_active", h_active, 0);
        chk("midrst_err_count", err_count, 0);
        idle(2);
        reset_n = 1'b1;
        pv_base = pv_cnt;
        line(8, 24'h00A000);
        line(5, 24'h0);
        cyc(1'b1, 1'b0, 1'b1, 24'h0);
        cyc(1'b1, 1'b0, 1'b1, 24'h0);
        idle(2);
        chk("prelock_locked", locked, 0);
        chk("prelock_pix_valid_count", pv_cnt - pv_base, 0);
        chk("prelock_err_flags", err_flags, 0);
        chk("prelock_err_count", err_count, 0);
        chk("prelock_h_active", h_active, 0);
        chk("prelock_slot_valid", slot_valid, 0);
        chk("prelock_v_total", v_total, 0);
        cyc(1'b0, 1'b1, 1'b0, 24'h0);
        chk("relock", locked, 1);
        chk("relock_err_flags", err_flags, 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
